// File: rtl/core_pkg.sv
// Shared definitions for the 4-bit-register pipelined core: widths, instruction
// field positions and the fetch FSM state encoding.
package core_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush to bubble beats load, otherwise contents hold.
module ifid_reg #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               valid,
  output logic [3:0]         op1,
  output logic [3:0]         op2
);
  import core_pkg::*;

  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pc_reg;
  logic               valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_reg <= INSTR_W'(NOP_INSTR);
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      instr_reg <= INSTR_W'(NOP_INSTR);
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
      valid_reg <= 1'b1;
    end
  end

  assign instr = instr_reg;
  assign pc    = pc_reg;
  assign valid = valid_reg;
  assign op1   = instr_reg[RS_MSB:RS_LSB];
  assign op2   = instr_reg[RT_MSB:RT_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to a variable-latency instruction
// memory that cannot cancel requests, and feeds the IF/ID register.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCWrite,
  input  logic               IFID_Write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IFID_instr,
  output logic [PC_W-1:0]    IFID_pc,
  output logic               IFID_valid,
  output logic [3:0]         IFID_op1,
  output logic [3:0]         IFID_op2
);
  import core_pkg::*;

  fetch_state_e       state_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [PC_W-1:0]    redir_pc_reg;
  logic [INSTR_W-1:0] hold_instr_reg;

  logic               advance;
  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_instr_next;

  assign advance = PCWrite & IFID_Write;

  // Request is live in FETCH and DISCARD; gated by reset so it drops at once.
  assign imem_req  = rst & (state_reg != ST_HOLD);
  assign imem_addr = pc_reg;

  always_comb begin
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    ifid_instr_next = imem_rdata;
    case (state_reg)
      ST_FETCH: begin
        if (branch_taken)    ifid_flush = 1'b1;
        else if (imem_ready) ifid_load  = advance;
        else if (IFID_Write) ifid_flush = 1'b1;
      end
      ST_DISCARD: begin
        ifid_flush = branch_taken | IFID_Write;
      end
      ST_HOLD: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
        end else if (advance) begin
          ifid_load       = 1'b1;
          ifid_instr_next = hold_instr_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      redir_pc_reg   <= '0;
      hold_instr_reg <= '0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (branch_taken) begin
            if (imem_ready) begin
              pc_reg <= branch_target;
            end else begin
              redir_pc_reg <= branch_target;
              state_reg    <= ST_DISCARD;
            end
          end else if (imem_ready) begin
            if (advance) begin
              pc_reg <= pc_reg + PC_W'(1);
            end else begin
              hold_instr_reg <= imem_rdata;
              state_reg      <= ST_HOLD;
            end
          end
        end
        ST_DISCARD: begin
          // The stale request must complete before the redirect takes effect.
          if (imem_ready) begin
            pc_reg    <= branch_taken ? branch_target : redir_pc_reg;
            state_reg <= ST_FETCH;
          end else if (branch_taken) begin
            redir_pc_reg <= branch_target;
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            pc_reg    <= branch_target;
            state_reg <= ST_FETCH;
          end else if (advance) begin
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= ST_FETCH;
          end
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (ifid_instr_next),
    .pc_in    (pc_reg),
    .instr    (IFID_instr),
    .pc       (IFID_pc),
    .valid    (IFID_valid),
    .op1      (IFID_op1),
    .op2      (IFID_op2)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-DISCARD sequence and
// a randomized run against a behavioural reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        IFID_Write;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] IFID_instr;
  logic [15:0] IFID_pc;
  logic        IFID_valid;
  logic [3:0]  IFID_op1;
  logic [3:0]  IFID_op2;

  logic        use_mem;
  logic [15:0] rand_rdata;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .PC_W     (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .IFID_Write    (IFID_Write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .IFID_instr    (IFID_instr),
    .IFID_pc       (IFID_pc),
    .IFID_valid    (IFID_valid),
    .IFID_op1      (IFID_op1),
    .IFID_op2      (IFID_op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed memory returns address + 0x1000; random phase returns random data.
  assign imem_rdata = use_mem ? (imem_addr + 16'h1000) : rand_rdata;

  typedef struct {
    logic        ready;
    logic        adv;
    logic        br;
    logic [15:0] tgt;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_req;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic e_valid, input logic [15:0] e_instr,
                           input logic [15:0] e_pc, input logic e_req, input logic [15:0] e_addr);
    logic [15:0] ei;
    ei = e_instr;
    check({tag, ".valid"}, 32'(IFID_valid), 32'(e_valid));
    check({tag, ".instr"}, 32'(IFID_instr), 32'(ei));
    check({tag, ".op1"},   32'(IFID_op1),   32'(ei[7:4]));
    check({tag, ".op2"},   32'(IFID_op2),   32'(ei[3:0]));
    if (e_valid) check({tag, ".pc"}, 32'(IFID_pc), 32'(e_pc));
    check({tag, ".req"}, 32'(imem_req), 32'(e_req));
    if (e_req) check({tag, ".addr"}, 32'(imem_addr), 32'(e_addr));
  endtask

  task automatic drive(input logic ready, input logic adv, input logic br, input logic [15:0] tgt);
    imem_ready    = ready;
    PCWrite       = adv;
    IFID_Write    = adv;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  // Called at a negedge with rst low; releases at the following negedge.
  task automatic reset_and_release(input string tag);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check_out({tag, ".in_reset"}, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    check({tag, ".in_reset.pc"}, 32'(IFID_pc), 32'h0);
    rst = 1'b1;
    #1;
    check({tag, ".release.req"},  32'(imem_req),  32'h1);
    check({tag, ".release.addr"}, 32'(imem_addr), 32'h0);
    $display("%s: reset released req=%b addr=%h", tag, imem_req, imem_addr);
  endtask

  // Reference model: PC, an outstanding stale request with its pending redirect,
  // and a one-entry buffer for an instruction returned during a stall.
  logic [15:0] m_pc, m_redir, m_buf;
  logic        m_stale, m_buf_full;
  logic        m_valid;
  logic [15:0] m_instr, m_ipc;

  task automatic model_reset();
    m_pc = 16'h0; m_redir = 16'h0; m_buf = 16'h0;
    m_stale = 1'b0; m_buf_full = 1'b0;
    m_valid = 1'b0; m_instr = 16'h0; m_ipc = 16'h0;
  endtask

  task automatic bubble();
    m_valid = 1'b0; m_instr = 16'h0;
  endtask

  task automatic model_step(input logic ready, input logic adv, input logic br,
                            input logic [15:0] tgt, input logic [15:0] data);
    if (m_buf_full) begin
      if (br) begin
        m_pc = tgt; m_buf_full = 1'b0; bubble();
      end else if (adv) begin
        m_valid = 1'b1; m_instr = m_buf; m_ipc = m_pc;
        m_pc = m_pc + 16'd1; m_buf_full = 1'b0;
      end
    end else if (m_stale) begin
      if (br || adv) bubble();
      if (ready) begin
        m_pc = br ? tgt : m_redir;
        m_stale = 1'b0;
      end else if (br) begin
        m_redir = tgt;
      end
    end else if (br) begin
      bubble();
      if (ready) m_pc = tgt;
      else begin m_stale = 1'b1; m_redir = tgt; end
    end else if (ready) begin
      if (adv) begin
        m_valid = 1'b1; m_instr = data; m_ipc = m_pc;
        m_pc = m_pc + 16'd1;
      end else begin
        m_buf = data; m_buf_full = 1'b1;
      end
    end else if (adv) begin
      bubble();
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 16'h0000, 1'b1, 16'h0001};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0001, 1'b1, 16'h0002};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0002, 1'b1, 16'h0003};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1003, 16'h0003, 1'b1, 16'h0004};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1004, 16'h0004, 1'b1, 16'h0005};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1004, 16'h0004, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1004, 16'h0004, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1005, 16'h0005, 1'b1, 16'h0006};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1006, 16'h0006, 1'b1, 16'h0007};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1007, 16'h0007, 1'b1, 16'h0008};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0008};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0008};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0008};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0040};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1040, 16'h0040, 1'b1, 16'h0041};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1041, 16'h0041, 1'b1, 16'h0042};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1041, 16'h0041, 1'b0, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1020, 16'h0020, 1'b1, 16'h0021};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0021};
    vecs[20] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0FFF, 16'hFFFF, 1'b1, 16'h0000};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 16'h0000, 1'b1, 16'h0001};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 16'h0077, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001};

    rst = 1'b0;
    use_mem = 1'b1;
    rand_rdata = 16'h0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    reset_and_release("init");

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ready, vecs[i].adv, vecs[i].br, vecs[i].tgt);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                vecs[i].e_pc, vecs[i].e_req, vecs[i].e_addr);
      $display("vec %0d ready=%b adv=%b br=%b tgt=%h -> valid=%b pc=%h instr=%h req=%b addr=%h",
               i, vecs[i].ready, vecs[i].adv, vecs[i].br, vecs[i].tgt,
               IFID_valid, IFID_pc, IFID_instr, imem_req, imem_addr);
    end

    // Asynchronous reset while DISCARD holds a pending redirect to 0x77.
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    #2 rst = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    check("async_rst.pc", 32'(IFID_pc), 32'h0);
    $display("async reset: valid=%b instr=%h pc=%h req=%b", IFID_valid, IFID_instr, IFID_pc, imem_req);
    @(negedge clk);
    reset_and_release("mid_discard");
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check_out("post_rst0", 1'b1, 16'h1000, 16'h0000, 1'b1, 16'h0001);
    $display("post reset: valid=%b pc=%h instr=%h addr=%h", IFID_valid, IFID_pc, IFID_instr, imem_addr);
    @(negedge clk);
    check_out("post_rst1", 1'b1, 16'h1001, 16'h0001, 1'b1, 16'h0002);
    $display("post reset: valid=%b pc=%h instr=%h addr=%h", IFID_valid, IFID_pc, IFID_instr, imem_addr);

    // Randomized run against the reference model.
    rst = 1'b0;
    use_mem = 1'b0;
    @(negedge clk);
    reset_and_release("rand");
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      logic        r_ready, r_adv, r_br;
      logic [15:0] r_tgt, r_data;
      r_ready = ($urandom_range(0, 99) < 65);
      r_adv   = ($urandom_range(0, 99) >= 25);
      r_br    = ($urandom_range(0, 99) < 8);
      r_tgt   = 16'($urandom);
      r_data  = 16'($urandom);
      rand_rdata = r_data;
      drive(r_ready, r_adv, r_br, r_tgt);
      model_step(r_ready, r_adv, r_br, r_tgt, r_data);
      @(negedge clk);
      check_out($sformatf("rand%0d", c), m_valid, m_instr, m_ipc, ~m_buf_full, m_pc);
      $display("rand %0d ready=%b adv=%b br=%b -> valid=%b pc=%h instr=%h req=%b addr=%h",
               c, r_ready, r_adv, r_br, IFID_valid, IFID_pc, IFID_instr, imem_req, imem_addr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
